chase_controller: RTL and testbench

Downstream consumer of the colour tracker's per-frame target estimate (x_center, y_center, radius). Once per video frame it samples the settled estimate and decides between searching, tracking and arrived behaviour. It converts horizontal error and apparent target size into left/right motor duty cycles, then drives two PWM outputs to the motor driver.

---
 rtl/chase_pkg.sv | 14 +
 rtl/pwm_gen.sv | 44 ++++
 rtl/chase_controller.sv | 190 +++++++++++++++++++
 tb/tb_chase_controller.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chase_pkg.sv
// Shared types and screen geometry for the chase controller.
package chase_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    TRACK   = 2'd1,
    ARRIVED = 2'd2
  } chase_state_t;

  localparam int SCREEN_W = 1024;
  localparam int SCREEN_H = 768;
  localparam int ERR_W    = 12;

endpackage

// File: rtl/pwm_gen.sv
// Prescaled PWM generator; duty and direction are latched only at the period wrap.
module pwm_gen #(
  parameter int PWM_BITS = 8,
  parameter int PWM_DIV  = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PWM_BITS-1:0] duty,
  input  logic                dir,
  output logic                pwm,
  output logic                dir_active
);

  localparam int PRE_W = (PWM_DIV > 0) ? $clog2(PWM_DIV + 1) : 1;

  logic [PRE_W-1:0]    presc;
  logic [PWM_BITS-1:0] cnt;
  logic [PWM_BITS-1:0] duty_active;
  logic                tick;
  logic                wrap;

  assign tick = (presc == PRE_W'(PWM_DIV));
  assign wrap = tick && (cnt == '1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc       <= '0;
      cnt         <= '0;
      duty_active <= '0;
      dir_active  <= 1'b1;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) cnt <= cnt + 1'b1;
      // A new duty only takes effect at the start of a full period.
      if (wrap) begin
        duty_active <= duty;
        dir_active  <= dir;
      end
    end
  end

  assign pwm = (cnt < duty_active);

endmodule

// File: rtl/chase_controller.sv
// Per-frame target chase FSM: samples the tracker estimate after vsync settles
// and drives left/right motor PWM with proportional steering.
module chase_controller #(
  parameter int CENTER_X      = 512,
  parameter int SETTLE_CYCLES = 64,
  parameter int MIN_RADIUS    = 4,
  parameter int STOP_RADIUS   = 80,
  parameter int HYST          = 8,
  parameter int BASE_SPEED    = 160,
  parameter int SEARCH_SPEED  = 96,
  parameter int KP_SHIFT      = 2,
  parameter int LOST_FRAMES   = 8,
  parameter int PWM_BITS      = 8,
  parameter int PWM_DIV       = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        vsync,
  input  logic [31:0] x_center,
  input  logic [31:0] y_center,
  input  logic [23:0] radius,
  output logic        left_pwm,
  output logic        right_pwm,
  output logic        left_dir,
  output logic        right_dir,
  output logic [1:0]  state,
  output logic        sample_pulse
);
  import chase_pkg::*;

  localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int MISS_W = $clog2(LOST_FRAMES);
  localparam logic signed [ERR_W+1:0] BASE_EXT = (ERR_W+2)'(BASE_SPEED);
  localparam logic signed [ERR_W+1:0] DUTY_MAX = (ERR_W+2)'((1 << PWM_BITS) - 1);

  logic             vs_meta, vs_sync, vs_prev, vs_fall;
  logic             settle_active;
  logic [SET_W-1:0] settle_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vs_meta <= 1'b0;
      vs_sync <= 1'b0;
      vs_prev <= 1'b0;
    end else begin
      vs_meta <= vsync;
      vs_sync <= vs_meta;
      vs_prev <= vs_sync;
    end
  end

  assign vs_fall = vs_prev & ~vs_sync;

  // A fresh falling edge always restarts the wait, aborting any pending sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      settle_active <= 1'b0;
      settle_cnt    <= '0;
      sample_pulse  <= 1'b0;
    end else begin
      sample_pulse <= 1'b0;
      if (vs_fall) begin
        settle_active <= 1'b1;
        settle_cnt    <= '0;
      end else if (settle_active) begin
        if (settle_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
          settle_active <= 1'b0;
          sample_pulse  <= 1'b1;
        end else begin
          settle_cnt <= settle_cnt + 1'b1;
        end
      end
    end
  end

  logic                    valid;
  logic [ERR_W-1:0]        err_u;
  logic signed [ERR_W-1:0] turn;
  logic signed [ERR_W+1:0] turn_ext, left_raw, right_raw;

  assign valid = (radius >= 24'(MIN_RADIUS)) &&
                 (x_center < 32'(SCREEN_W)) && (y_center < 32'(SCREEN_H));
  assign err_u     = {1'b0, x_center[10:0]} - ERR_W'(CENTER_X);
  assign turn      = $signed(err_u) >>> KP_SHIFT;
  assign turn_ext  = {{2{turn[ERR_W-1]}}, turn};
  assign left_raw  = BASE_EXT + turn_ext;
  assign right_raw = BASE_EXT - turn_ext;

  function automatic logic [PWM_BITS-1:0] sat_duty(input logic signed [ERR_W+1:0] v);
    if (v < 0)             sat_duty = '0;
    else if (v > DUTY_MAX) sat_duty = '1;
    else                   sat_duty = v[PWM_BITS-1:0];
  endfunction

  chase_state_t        cur_state;
  logic [MISS_W-1:0]   miss_cnt;
  logic [PWM_BITS-1:0] left_duty, right_duty;
  logic                left_dir_q, right_dir_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state   <= SEARCH;
      miss_cnt    <= '0;
      left_duty   <= '0;
      right_duty  <= '0;
      left_dir_q  <= 1'b1;
      right_dir_q <= 1'b1;
    end else if (!enable) begin
      cur_state   <= SEARCH;
      miss_cnt    <= '0;
      left_duty   <= '0;
      right_duty  <= '0;
      left_dir_q  <= 1'b1;
      right_dir_q <= 1'b1;
    end else if (sample_pulse) begin
      case (cur_state)
        SEARCH: begin
          miss_cnt <= '0;
          if (valid) begin
            cur_state   <= TRACK;
            left_duty   <= sat_duty(left_raw);
            right_duty  <= sat_duty(right_raw);
            left_dir_q  <= 1'b1;
            right_dir_q <= 1'b1;
          end else begin
            left_duty   <= PWM_BITS'(SEARCH_SPEED);
            right_duty  <= PWM_BITS'(SEARCH_SPEED);
            left_dir_q  <= 1'b1;
            right_dir_q <= 1'b0;
          end
        end
        TRACK, ARRIVED: begin
          if (valid) begin
            miss_cnt <= '0;
            // Entering ARRIVED uses the full stop radius; leaving needs the hysteresis margin.
            if ((cur_state == TRACK) ? (radius >= 24'(STOP_RADIUS))
                                     : (radius >= 24'(STOP_RADIUS - HYST))) begin
              cur_state   <= ARRIVED;
              left_duty   <= '0;
              right_duty  <= '0;
              left_dir_q  <= 1'b1;
              right_dir_q <= 1'b1;
            end else begin
              cur_state   <= TRACK;
              left_duty   <= sat_duty(left_raw);
              right_duty  <= sat_duty(right_raw);
              left_dir_q  <= 1'b1;
              right_dir_q <= 1'b1;
            end
          end else if (miss_cnt == MISS_W'(LOST_FRAMES - 1)) begin
            cur_state   <= SEARCH;
            miss_cnt    <= '0;
            left_duty   <= PWM_BITS'(SEARCH_SPEED);
            right_duty  <= PWM_BITS'(SEARCH_SPEED);
            left_dir_q  <= 1'b1;
            right_dir_q <= 1'b0;
          end else begin
            miss_cnt <= miss_cnt + 1'b1;
          end
        end
        default: begin
          cur_state <= SEARCH;
          miss_cnt  <= '0;
        end
      endcase
    end
  end

  assign state = cur_state;

  pwm_gen #(.PWM_BITS(PWM_BITS), .PWM_DIV(PWM_DIV)) u_left_pwm (
    .clk        (clk),
    .reset      (reset),
    .duty       (left_duty),
    .dir        (left_dir_q),
    .pwm        (left_pwm),
    .dir_active (left_dir)
  );

  pwm_gen #(.PWM_BITS(PWM_BITS), .PWM_DIV(PWM_DIV)) u_right_pwm (
    .clk        (clk),
    .reset      (reset),
    .duty       (right_duty),
    .dir        (right_dir_q),
    .pwm        (right_pwm),
    .dir_active (right_dir)
  );

endmodule

// File: tb/tb_chase_controller.sv
// Bench for chase_controller: frame-level behavioural model checked every cycle,
// plus directed frames with hand-computed duties and timing.
module tb_chase_controller;

  localparam int SETTLE = 64;
  localparam int DIV    = 1;
  localparam int PERIOD = 256 * (DIV + 1);
  localparam int LAT    = SETTLE + 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b1;
  logic        vsync = 1'b1;
  logic [31:0] x_center = 32'd512;
  logic [31:0] y_center = 32'd300;
  logic [23:0] radius = 24'd0;
  logic        left_pwm, right_pwm, left_dir, right_dir, sample_pulse;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  chase_controller #(.SETTLE_CYCLES(SETTLE), .PWM_DIV(DIV)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .vsync        (vsync),
    .x_center     (x_center),
    .y_center     (y_center),
    .radius       (radius),
    .left_pwm     (left_pwm),
    .right_pwm    (right_pwm),
    .left_dir     (left_dir),
    .right_dir    (right_dir),
    .state        (state),
    .sample_pulse (sample_pulse)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Frame-level model: state after the most recent clock edge.
  int m_state, m_miss, m_left, m_right, m_ldir, m_rdir;
  int act_l, act_r, act_ld, act_rd;
  int k, prev_v;
  bit m_pulse;
  int falls[$];

  function automatic int clampDuty(input int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  function automatic int steerTurn(input int x);
    int e;
    e = x - 512;
    if (e >= 0) return e / 4;
    return -((-e + 3) / 4);
  endfunction

  function automatic bit pulseAt(input int j);
    bit ok;
    foreach (falls[i]) begin
      if (j - falls[i] == LAT) begin
        ok = 1'b1;
        foreach (falls[g])
          if (falls[g] > falls[i] && falls[g] <= j - 3) ok = 1'b0;
        if (ok) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic modelReset();
    m_state = 0; m_miss = 0; m_left = 0; m_right = 0; m_ldir = 1; m_rdir = 1;
    act_l = 0; act_r = 0; act_ld = 1; act_rd = 1;
    k = 0; prev_v = 0; m_pulse = 1'b0;
    falls.delete();
  endtask

  task automatic modelStep();
    int n_state, n_miss, n_l, n_r, n_ld, n_rd, t;
    bit valid;
    n_state = m_state; n_miss = m_miss; n_l = m_left; n_r = m_right;
    n_ld = m_ldir; n_rd = m_rdir;
    valid = (radius >= 4) && (x_center < 1024) && (y_center < 768);
    t = steerTurn(int'(x_center));
    if (!enable) begin
      n_state = 0; n_miss = 0; n_l = 0; n_r = 0; n_ld = 1; n_rd = 1;
    end else if (m_pulse) begin
      if (m_state == 0) begin
        n_miss = 0;
        if (valid) begin
          n_state = 1; n_l = clampDuty(160 + t); n_r = clampDuty(160 - t); n_ld = 1; n_rd = 1;
        end else begin
          n_l = 96; n_r = 96; n_ld = 1; n_rd = 0;
        end
      end else if (valid) begin
        n_miss = 0;
        if ((m_state == 1 && radius >= 80) || (m_state == 2 && radius >= 72)) begin
          n_state = 2; n_l = 0; n_r = 0; n_ld = 1; n_rd = 1;
        end else begin
          n_state = 1; n_l = clampDuty(160 + t); n_r = clampDuty(160 - t); n_ld = 1; n_rd = 1;
        end
      end else if (m_miss + 1 >= 8) begin
        n_state = 0; n_miss = 0; n_l = 96; n_r = 96; n_ld = 1; n_rd = 0;
      end else begin
        n_miss = m_miss + 1;
      end
    end
    if ((k + 1) % PERIOD == 0) begin
      act_l = m_left; act_r = m_right; act_ld = m_ldir; act_rd = m_rdir;
    end
    m_state = n_state; m_miss = n_miss; m_left = n_l; m_right = n_r;
    m_ldir = n_ld; m_rdir = n_rd;
    if (prev_v == 1 && vsync == 1'b0) falls.push_back(k);
    prev_v = int'(vsync);
    k++;
    m_pulse = pulseAt(k);
  endtask

  initial begin : compare_proc
    int pos;
    modelReset();
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        checkOutput("rst_state", int'(state), 0);
        checkOutput("rst_lpwm", int'(left_pwm), 0);
        checkOutput("rst_rpwm", int'(right_pwm), 0);
        checkOutput("rst_ldir", int'(left_dir), 1);
        checkOutput("rst_rdir", int'(right_dir), 1);
        checkOutput("rst_pulse", int'(sample_pulse), 0);
        modelReset();
      end else begin
        pos = (k / (DIV + 1)) % 256;
        checkOutput("cyc_state", int'(state), m_state);
        checkOutput("cyc_pulse", int'(sample_pulse), int'(m_pulse));
        checkOutput("cyc_lpwm", int'(left_pwm), (pos < act_l) ? 1 : 0);
        checkOutput("cyc_rpwm", int'(right_pwm), (pos < act_r) ? 1 : 0);
        checkOutput("cyc_ldir", int'(left_dir), act_ld);
        checkOutput("cyc_rdir", int'(right_dir), act_rd);
        modelStep();
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y, input logic [23:0] r);
    @(negedge clk);
    x_center = x; y_center = y; radius = r; vsync = 1'b0;
    repeat (4) @(negedge clk);
    vsync = 1'b1;
    repeat (SETTLE + 12) @(negedge clk);
  endtask

  task automatic measurePwm(input string name, input int exp_l, input int exp_r,
                            input int exp_ld, input int exp_rd);
    int cl, cr;
    cl = 0; cr = 0;
    repeat (PERIOD + 4) @(negedge clk);
    repeat (PERIOD) begin
      @(negedge clk);
      #1;
      cl += int'(left_pwm);
      cr += int'(right_pwm);
    end
    checkOutput({name, "_lhigh"}, cl, exp_l);
    checkOutput({name, "_rhigh"}, cr, exp_r);
    checkOutput({name, "_ldir"}, int'(left_dir), exp_ld);
    checkOutput({name, "_rdir"}, int'(right_dir), exp_rd);
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int pulses, when;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_state", int'(state), 0);
    checkOutput("reset_lpwm", int'(left_pwm), 0);
    checkOutput("reset_ldir", int'(left_dir), 1);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    applyStimulus(512, 300, 20);
    applyStimulus(512, 300, 20);
    checkOutput("center_state", int'(state), 1);
    measurePwm("center", 320, 320, 1, 1);

    applyStimulus(612, 300, 20);
    checkOutput("model_l612", m_left, 185);
    checkOutput("model_r612", m_right, 135);
    measurePwm("x612", 370, 270, 1, 1);

    applyStimulus(1000, 300, 20);
    checkOutput("model_r1000", m_right, 38);
    measurePwm("x1000", 510, 76, 1, 1);

    applyStimulus(0, 300, 20);
    measurePwm("x0", 64, 510, 1, 1);

    applyStimulus(612, 300, 20);
    for (int i = 0; i < 7; i++) applyStimulus(612, 300, 2);
    checkOutput("lost7_state", int'(state), 1);
    measurePwm("held", 370, 270, 1, 1);
    applyStimulus(612, 300, 2);
    checkOutput("lost8_state", int'(state), 0);
    measurePwm("spin", 192, 192, 1, 0);

    applyStimulus(512, 300, 20);
    checkOutput("retrack_state", int'(state), 1);
    applyStimulus(512, 300, 90);
    checkOutput("arrive_state", int'(state), 2);
    measurePwm("arrived", 0, 0, 1, 1);
    applyStimulus(512, 300, 75);
    checkOutput("hyst75_state", int'(state), 2);
    applyStimulus(512, 300, 71);
    checkOutput("hyst71_state", int'(state), 1);
    checkOutput("model_l71", m_left, 160);

    pulses = 0; when = -1;
    for (int c = 0; c < 160; c++) begin
      @(negedge clk);
      if (c == 0 || c == 30) vsync = 1'b0;
      if (c == 3 || c == 33) vsync = 1'b1;
      #1;
      if (sample_pulse) begin
        pulses++;
        when = c;
      end
    end
    checkOutput("dbl_pulses", pulses, 1);
    checkOutput("dbl_delay_ok", (when - 30 >= SETTLE && when - 30 <= SETTLE + 4) ? 1 : 0, 1);

    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("disable_state", int'(state), 0);
    applyStimulus(512, 300, 20);
    checkOutput("disable_frame_state", int'(state), 0);
    measurePwm("disabled", 0, 0, 1, 1);
    @(negedge clk);
    enable = 1'b1;
    applyStimulus(512, 300, 20);
    checkOutput("reenable_state", int'(state), 1);

    @(negedge clk);
    vsync = 1'b0;
    repeat (3) @(negedge clk);
    vsync = 1'b1;
    repeat (20) @(negedge clk);
    #3 reset = 1'b0;
    #1;
    checkOutput("async_state", int'(state), 0);
    checkOutput("async_lpwm", int'(left_pwm), 0);
    checkOutput("async_rpwm", int'(right_pwm), 0);
    checkOutput("async_pulse", int'(sample_pulse), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    repeat (100) begin
      @(negedge clk);
      #1;
      if (sample_pulse) pulses++;
    end
    checkOutput("post_reset_pulses", pulses, 0);
    applyStimulus(512, 300, 20);
    checkOutput("post_reset_track", int'(state), 1);

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
